// File: rtl/ascon_msg_loader_if.sv
// Loader-side bus: message handshake from the host plus the serial and control lines to the ASCON core.
interface ascon_msg_loader_if #(
  parameter int unsigned Y = 40
) ();
  logic [Y-1:0] msg_in;
  logic         msg_valid;
  logic         msg_ready;
  logic         readyxSI;
  logic [2:0]   messagexSO;
  logic [6:0]   r_64xSO;
  logic         r_faultxSO;
  logic         startxSO;
  logic         done;

  modport master (
    output msg_in, msg_valid, readyxSI,
    input  msg_ready, messagexSO, r_64xSO, r_faultxSO, startxSO, done
  );

  modport slave (
    input  msg_in, msg_valid, readyxSI,
    output msg_ready, messagexSO, r_64xSO, r_faultxSO, startxSO, done
  );
endinterface

// File: rtl/ascon_msg_loader.sv
// Serialises a parallel message into the ASCON core MSB-first with LFSR randomness,
// then pulses start and waits for the core to report completion.
module ascon_msg_loader #(
  parameter int unsigned Y            = 40,
  parameter int unsigned MAX          = 256,
  parameter int unsigned START_CYCLES = 2,
  parameter logic [31:0] SEED         = 32'hACE1_2024
) (
  input logic                clk,
  input logic                rst,
  ascon_msg_loader_if.slave  bus
);

  localparam int unsigned CW       = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_CORE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [Y-1:0]    sh_q, sh_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic            ready_q, ready_d;
  logic            bit_q, bit_d;
  logic [9:0]      rnd_q, rnd_d;
  logic            start_q, start_d;
  logic            done_q, done_d;

  // Fibonacci LFSR, taps 32,22,2,1
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Next state; outputs are derived from next-state values so they register cycle-aligned
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    lfsr_d  = lfsr_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.msg_valid) begin
          state_d = LOAD;
          cnt_d   = '0;
          sh_d    = bus.msg_in;
        end
      end
      LOAD: begin
        lfsr_d = lfsr_step(lfsr_q);
        sh_d   = sh_q << 1;
        if (cnt_q == CW'(MAX - 1)) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      START: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          state_d = WAIT_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_CORE: begin
        if (bus.readyxSI) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    start_d = (state_d == START);
    bit_d   = (state_d == LOAD) ? sh_d[Y-1] : 1'b0;
    if (state_d == LOAD) rnd_d = lfsr_d[9:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      lfsr_q  <= SEED_EFF;
      ready_q <= 1'b1;
      bit_q   <= 1'b0;
      rnd_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
      bit_q   <= bit_d;
      rnd_q   <= rnd_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign bus.msg_ready  = ready_q;
  assign bus.messagexSO = {rnd_q[1:0], bit_q};
  assign bus.r_64xSO    = rnd_q[8:2];
  assign bus.r_faultxSO = rnd_q[9];
  assign bus.startxSO   = start_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_ascon_msg_loader.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_ascon_msg_loader;

  localparam int unsigned Y     = 40;
  localparam int unsigned MAX   = 256;
  localparam int unsigned SC    = 2;
  localparam logic [31:0] SEED  = 32'hACE1_2024;

  typedef struct {
    logic [2:0] msg;
    logic [6:0] r64;
    logic       rf;
    logic       st;
    logic       dn;
    logic       rdy;
    logic [9:0] rnd0;
    string      tag;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [31:0] m_lfsr, m_lfsr0;
  logic [9:0]  exp_rnd, exp_rnd0;

  ascon_msg_loader_if #(.Y(Y)) bus  ();
  ascon_msg_loader_if #(.Y(Y)) bus0 ();

  assign bus0.msg_in    = bus.msg_in;
  assign bus0.msg_valid = bus.msg_valid;
  assign bus0.readyxSI  = bus.readyxSI;

  ascon_msg_loader #(.Y(Y), .MAX(MAX), .START_CYCLES(SC), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ascon_msg_loader #(.Y(Y), .MAX(MAX), .START_CYCLES(SC), .SEED(32'h0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] nxt(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Monitor: one expected record per cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [23:0] act, expv;
      e    = exp_q.pop_front();
      act  = {bus.messagexSO, bus.r_64xSO, bus.r_faultxSO, bus.startxSO, bus.done, bus.msg_ready,
              bus0.r_faultxSO, bus0.r_64xSO, bus0.messagexSO[2:1]};
      expv = {e.msg, e.r64, e.rf, e.st, e.dn, e.rdy, e.rnd0};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", e.tag, e.cyc, act, expv);
      end
    end
  end

  task automatic push(input logic b0, input logic st, input logic dn, input logic rdy, input string tag);
    exp_t e;
    e.msg  = {exp_rnd[1:0], b0};
    e.r64  = exp_rnd[8:2];
    e.rf   = exp_rnd[9];
    e.st   = st;
    e.dn   = dn;
    e.rdy  = rdy;
    e.rnd0 = exp_rnd0;
    e.tag  = tag;
    e.cyc  = cyc;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic step(input logic b0, input logic st, input logic dn, input logic rdy,
                      input bit load, input string tag);
    @(posedge clk); #1;
    if (load) begin
      exp_rnd  = m_lfsr[9:0];
      exp_rnd0 = m_lfsr0[9:0];
      m_lfsr   = nxt(m_lfsr);
      m_lfsr0  = nxt(m_lfsr0);
    end
    push(b0, st, dn, rdy, tag);
  endtask

  task automatic rst_step();
    @(posedge clk); #1;
    m_lfsr   = SEED;
    m_lfsr0  = 32'h1;
    exp_rnd  = '0;
    exp_rnd0 = '0;
    push(1'b0, 1'b0, 1'b0, 1'b1, "reset");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "idle");
  endtask

  // One message: load (optional abort), start, wait for core, done pulse
  task automatic run_msg(input logic [Y-1:0] m, input int abort_at, input bit hold_valid,
                         input bit ready_early, input int wait_cycles);
    logic b;
    bus.msg_in    = m;
    bus.msg_valid = 1'b1;
    for (int i = 0; i < int'(MAX); i++) begin
      b = (i < int'(Y)) ? m[int'(Y) - 1 - i] : 1'b0;
      step(b, 1'b0, 1'b0, 1'b0, 1'b1, "load");
      bus.msg_valid = hold_valid;
      bus.readyxSI  = (i == 60);
      if (i == abort_at) begin
        rst = 1'b1;
        bus.readyxSI = 1'b0;
        rst_step();
        rst = 1'b0;
        bus.msg_valid = 1'b0;
        return;
      end
    end
    bus.readyxSI = ready_early;
    for (int j = 0; j < int'(SC); j++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start");
    if (ready_early) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wait");
    end else begin
      for (int k = 0; k < wait_cycles; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wait");
      bus.readyxSI = 1'b1;
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "done");
    bus.readyxSI = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.msg_in    = '0;
    bus.msg_valid = 1'b0;
    bus.readyxSI  = 1'b0;
    m_lfsr        = SEED;
    m_lfsr0       = 32'h1;
    exp_rnd       = '0;
    exp_rnd0      = '0;

    rst_step();
    rst_step();
    rst = 1'b0;
    idle(3);

    // "ascon": first serial bits 0,1,1,0,0,0,0,1; core ready pulse mid-load is ignored
    run_msg(40'h6173636f6e, -1, 1'b0, 1'b0, 5);
    idle(2);

    // core already ready on WAIT_CORE entry
    run_msg(40'hA50F3CC381, -1, 1'b0, 1'b1, 0);
    idle(1);

    // reset at load counter 100, start must stay low afterwards
    run_msg(40'hFFFFFFFFFF, 100, 1'b0, 1'b0, 0);
    idle(10);

    // LFSR restarts from seed; msg_valid held high gives back-to-back acceptance after done
    run_msg(40'h0123456789, -1, 1'b1, 1'b0, 3);
    run_msg(40'h8000000001, -1, 1'b0, 1'b0, 2);
    idle(2);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
